dram_port_arbiter: RTL
======================

Name: dram_port_arbiter

Overview:
- Shares one single-port DRAM request channel between the instruction-cache miss path (port 1, read-only) and the data-cache miss/writeback path (port 2, read/write).
- Sits between icache_controller/dcache_controller and a single-ported dram_controller.
- Arbitrates round-robin, latches the winning request, and drives the DRAM handshake.
- Returns the block and a one-cycle acknowledge to the winner, and drives the global dram_busy used in the memory-stall term.

Parameters:
ADDR_W, 32, byte address width (matches DRAM_ADDRESS_SIZE)
WORD_W, 32, word width (matches DRAM_WORD_SIZE)
BLOCK_WORDS, 4, words per cache block (matches DRAM_BLOCK_SIZE)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
p1_address  in  ADDR_W  icache block request address
p1_request  in  1  icache request valid; held until p1_acknowledge
p1_read_data  out  WORD_W x BLOCK_WORDS  block returned to icache
p1_acknowledge  out  1  one-cycle completion pulse to icache
p2_address  in  ADDR_W  dcache block request address
p2_we  in  1  1 = block write, 0 = block read
p2_write_data  in  WORD_W x BLOCK_WORDS  writeback block
p2_request  in  1  dcache request valid; held until p2_acknowledge
p2_read_data  out  WORD_W x BLOCK_WORDS  block returned to dcache (reads only)
p2_acknowledge  out  1  one-cycle completion pulse to dcache
mem_address  out  ADDR_W  latched address to DRAM
mem_we  out  1  latched write enable to DRAM
mem_write_data  out  WORD_W x BLOCK_WORDS  latched write block to DRAM
mem_request  out  1  DRAM request valid
mem_read_data  in  WORD_W x BLOCK_WORDS  DRAM read block, valid with mem_ready
mem_ready  in  1  DRAM completion, single-cycle pulse
dram_busy  out  1  high whenever state != IDLE
grant_debug  out  2  00 none, 01 port1, 10 port2

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, last_grant=port1 (so port2 wins the first tie), all outputs 0, read-data registers 0. Reset mid-transaction abandons it; no acknowledge is issued; the DRAM controller is reset on the same edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not equal to last_grant.
  - On grant: latch address/we/write_data into the mem_* registers (port1 forces we=0), set grant_debug and last_grant, go to ISSUE.
- ISSUE: mem_request=1, dram_busy=1. Go to WAIT.
- WAIT:
  - mem_request held at 1 with mem_* stable until mem_ready.
  - On mem_ready: capture mem_read_data into the granted port's read_data register (only if we=0; write grants leave read_data unchanged), drop mem_request, go to RESP.
  - mem_ready seen in ISSUE is treated identically.
- RESP: assert the granted port's acknowledge for exactly one cycle, clear grant_debug, go to IDLE.
- Read data is held stable until that port's next read completes.
- Latency: request sampled at edge N → mem_request high at N+1. mem_ready sampled at edge M → acknowledge high for cycle M+1 → IDLE at M+2. With mem_ready one cycle after mem_request, minimum request-to-ack is 3 cycles.
- Requesters must deassert request in the cycle after acknowledge. The RESP→IDLE spacing guarantees a completed request is never re-granted.
- A request dropped mid-transaction does not abort it; the transaction completes and the acknowledge still pulses.
- Request inputs are ignored outside IDLE. Newly raised requests wait and are arbitrated in the next IDLE.
- Fairness: with both ports continuously requesting, grants strictly alternate. A port never waits more than one foreign transaction.
- mem_ready while in IDLE or RESP is ignored.
- p1_acknowledge and p2_acknowledge are never high together. Never more than one outstanding DRAM request.

Test Plan:
- Reset: hold reset 2 cycles with both requests high → all outputs 0, dram_busy=0; the first grant after release goes to port2 (grant_debug=10).
- Single icache read: p1_address=0x0000_0040, mem_ready 3 cycles after mem_request, mem_read_data={0x11,0x22,0x33,0x44} → mem_address=0x40, mem_we=0, p1_read_data equals that block, p1_acknowledge a single pulse one cycle after mem_ready, p2 outputs untouched.
- dcache writeback: p2_we=1, p2_address=0x100, write block {0xA,0xB,0xC,0xD} → mem_we=1, mem_write_data matches and stays stable through WAIT, p2_acknowledge pulses once, p2_read_data unchanged.
- Contention: both requesting continuously for 4 transactions → grant order port2, port1, port2, port1; dram_busy stays high except one IDLE cycle between transactions.
- Late arrival: p1 raised during a port2 WAIT → p1 granted in the IDLE immediately after the p2 RESP; mem_address changes only in that grant cycle.
- Reset mid-WAIT: reset asserted 1 cycle after mem_request → next cycle mem_request=0, no acknowledge pulse, state IDLE; a fresh p1 request then completes normally.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin arbiter sharing one DRAM request channel between icache and dcache
module dram_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ADDR_W-1:0]                    p1_address,
  input  logic                                 p1_request,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   p1_read_data,
  output logic                                 p1_acknowledge,
  input  logic [ADDR_W-1:0]                    p2_address,
  input  logic                                 p2_we,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   p2_write_data,
  input  logic                                 p2_request,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   p2_read_data,
  output logic                                 p2_acknowledge,
  output logic [ADDR_W-1:0]                    mem_address,
  output logic                                 mem_we,
  output logic [BLOCK_WORDS-1:0][WORD_W-1:0]   mem_write_data,
  output logic                                 mem_request,
  input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]   mem_read_data,
  input  logic                                 mem_ready,
  output logic                                 dram_busy,
  output logic [1:0]                           grant_debug
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P1   = 2'b01;
  localparam logic [1:0] GNT_P2   = 2'b10;

  state_t state, state_nxt;
  logic   last_p2, last_p2_nxt;
  logic   grant_p2;

  logic [ADDR_W-1:0]                  mem_address_nxt;
  logic                               mem_we_nxt;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] mem_write_data_nxt;
  logic                               mem_request_nxt;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] p1_read_data_nxt;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] p2_read_data_nxt;
  logic                               p1_acknowledge_nxt;
  logic                               p2_acknowledge_nxt;
  logic                               dram_busy_nxt;
  logic [1:0]                         grant_debug_nxt;

  // Port 2 wins when alone or when port 1 was served last; otherwise port 1.
  assign grant_p2 = p2_request && (!p1_request || !last_p2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      last_p2        <= 1'b0;
      mem_address    <= '0;
      mem_we         <= 1'b0;
      mem_write_data <= '0;
      mem_request    <= 1'b0;
      p1_read_data   <= '0;
      p2_read_data   <= '0;
      p1_acknowledge <= 1'b0;
      p2_acknowledge <= 1'b0;
      dram_busy      <= 1'b0;
      grant_debug    <= GNT_NONE;
    end else begin
      state          <= state_nxt;
      last_p2        <= last_p2_nxt;
      mem_address    <= mem_address_nxt;
      mem_we         <= mem_we_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_request    <= mem_request_nxt;
      p1_read_data   <= p1_read_data_nxt;
      p2_read_data   <= p2_read_data_nxt;
      p1_acknowledge <= p1_acknowledge_nxt;
      p2_acknowledge <= p2_acknowledge_nxt;
      dram_busy      <= dram_busy_nxt;
      grant_debug    <= grant_debug_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (p1_request || p2_request) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = mem_ready ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_ready) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    last_p2_nxt        = last_p2;
    mem_address_nxt    = mem_address;
    mem_we_nxt         = mem_we;
    mem_write_data_nxt = mem_write_data;
    mem_request_nxt    = mem_request;
    p1_read_data_nxt   = p1_read_data;
    p2_read_data_nxt   = p2_read_data;
    p1_acknowledge_nxt = 1'b0;
    p2_acknowledge_nxt = 1'b0;
    grant_debug_nxt    = grant_debug;
    // Registered copy of the state decode so dram_busy tracks state exactly.
    dram_busy_nxt      = (state_nxt != S_IDLE);
    case (state)
      S_IDLE: begin
        if (p1_request || p2_request) begin
          mem_address_nxt    = grant_p2 ? p2_address : p1_address;
          mem_we_nxt         = grant_p2 && p2_we;
          mem_write_data_nxt = grant_p2 ? p2_write_data : '0;
          mem_request_nxt    = 1'b1;
          grant_debug_nxt    = grant_p2 ? GNT_P2 : GNT_P1;
          last_p2_nxt        = grant_p2;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (mem_ready) begin
          mem_request_nxt = 1'b0;
          if (grant_debug == GNT_P2) begin
            p2_acknowledge_nxt = 1'b1;
            if (!mem_we) p2_read_data_nxt = mem_read_data;
          end else begin
            p1_acknowledge_nxt = 1'b1;
            if (!mem_we) p1_read_data_nxt = mem_read_data;
          end
        end
      end
      S_RESP: grant_debug_nxt = GNT_NONE;
      default: ;
    endcase
  end

endmodule
